// File: rtl/uart_pkg.sv
// Shared UART byte type and default receive-buffer depth.
package uart_pkg;

    localparam int UART_BYTE_W            = 8;
    localparam int UART_RX_FIFO_DEPTH_DEF = 16;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one asynchronous read port.
// Storage is deliberately left without reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  uart_byte_t    wdata,
    input  logic [AW-1:0] raddr,
    output uart_byte_t    rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART RX deserializer.
// Optional sticky drop flag enabled by defining UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   wr_stb,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        rd_fire;
    logic        wr_fire;
    uart_byte_t  mem_rdata;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_valid = !empty;
    assign rd_fire  = rd_valid && rd_ready;
    // A read on the same edge frees the slot, so a write while full still lands.
    assign wr_fire  = wr_stb && (!full || rd_fire);
    assign rd_data  = rd_valid ? mem_rdata : '0;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic drop;

    assign drop = wr_stb && full && !rd_fire;

    // Set has priority over clear so a coincident drop is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_overrun_clr;

    assign unused_overrun_clr = overrun_clr;
    assign overrun            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; honours UART_RX_FIFO_OVERRUN_EN when defined.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic       overrun_clr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    int         m_count = 0;
    logic       m_ovr = 1'b0;

    uart_rx_fifo #(
        .DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_stb      (wr_stb),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .count       (count),
        .full        (full),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is visible half a cycle before the edge that completes it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_valid_mon", {31'd0, rd_valid}, {31'd0, (m_count != 0)});
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=%0h required=none", rd_data);
                end else begin
                    chk("rd_data_pop", {24'd0, rd_data}, {24'd0, sb[0]});
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Entered and left at posedge+1; drives one cycle and checks state after the edge.
    task automatic step(input logic ws, input logic [7:0] wd, input logic rr, input logic clr);
        logic rd;
        logic wr;
        logic drop;
        wr_stb      = ws;
        wr_data     = wd;
        rd_ready    = rr;
        overrun_clr = clr;
        rd   = rr && (m_count > 0);
        wr   = ws && ((m_count < 16) || rd);
        drop = ws && !wr;
        if (wr) sb.push_back(wd);
        @(posedge clk);
        #1;
        m_count = m_count + int'(wr) - int'(rd);
`ifdef UART_RX_FIFO_OVERRUN_EN
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
`else
        m_ovr = 1'b0;
        if (drop) m_ovr = 1'b0;
`endif
        wr_stb      = 1'b0;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
        chk("count", {27'd0, count}, m_count);
        chk("full", {31'd0, full}, {31'd0, (m_count == 16)});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (m_count > 0) chk("rd_data_head", {24'd0, rd_data}, {24'd0, sb[0]});
        else             chk("rd_data_empty", {24'd0, rd_data}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        wr_data     = '0;
        wr_stb      = 1'b0;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_count", {27'd0, count}, 32'd0);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Two bytes, then read both
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("first_byte_visible", {24'd0, rd_data}, 32'h0000_00A5);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("count_two", {27'd0, count}, 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill, overflow, then write+read while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_at_16", {31'd0, full}, 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("count_stays_16", {27'd0, count}, 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Wrap-around pairs
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Asynchronous reset with 5 bytes stored
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("async_count", {27'd0, count}, 32'd0);
        m_count = 0;
        m_ovr   = 1'b0;
        sb.delete();
        wr_stb  = 1'b1;
        wr_data = 8'hEE;
        @(posedge clk);
        #1;
        wr_stb = 1'b0;
        chk("reset_ignores_wr", {27'd0, count}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Drop and clear in the same cycle, then a plain clear
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
